// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data/instruction bus: single-port word array with
// pipelined fixed-latency reads, single-cycle writes, a side load port and a post-reset clear sweep.
module data_mem_responder #(
    parameter int unsigned MEM_DEPTH      = 4096,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_tb,
    input  logic                  en,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] dout_cpu,
    output logic [DATA_WIDTH-1:0] din_cpu,
    output logic                  rd_valid,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_CLEAR,
        ST_SERVE
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld_q;

    logic                    serve;
    logic                    rd_issue;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    assign serve    = reset && (state_q == ST_SERVE);
    // A simultaneous write takes priority, so a read issues only without wr_en.
    assign rd_issue = serve && en && rd_en && !wr_en;
    assign cnt_d    = cnt_q + CNT_WIDTH'(1);

    // Single write port: clear sweep, then load port, then CPU write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_WIDTH-1:0];
            end else if (ld_en) begin
                mem_we    = 1'b1;
                mem_waddr = ld_addr;
                mem_wdata = ld_data;
            end else if (en && wr_en) begin
                mem_we    = 1'b1;
                mem_waddr = addr_tb;
                mem_wdata = dout_cpu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Clear/serve control; the extra counter bit marks completion without wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            busy_q  <= CLEAR_ON_RESET;
            cnt_q   <= '0;
        end else if (state_q == ST_CLEAR) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_WIDTH'(MEM_DEPTH)) begin
                state_q <= ST_SERVE;
                busy_q  <= 1'b0;
            end
        end
    end

    // Read pipeline: stages only load on valid, so the last stage holds the previous result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_issue;
            if (rd_issue) begin
                pipe_data_q[0] <= mem_q[addr_tb];
            end
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    assign din_cpu  = pipe_data_q[READ_LATENCY-1];
    assign rd_valid = pipe_vld_q[READ_LATENCY-1];
    assign busy     = busy_q;

endmodule
